// File: rtl/mix_columns_seq_if.sv
// Handshake and byte-unit bus for the mixColumns sequencer.
// The slave modport is the sequencer. The master modport is the surrounding datapath,
// which supplies the input state, the mixColumns unit result and the output ready.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         in_bypass;
  logic [1:0]   mc_row;
  logic [7:0]   mc_col0;
  logic [7:0]   mc_col1;
  logic [7:0]   mc_col2;
  logic [7:0]   mc_col3;
  logic [7:0]   mc_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport slave (
    input  in_valid, state_in, in_bypass, mc_result, out_ready,
    output in_ready, mc_row, mc_col0, mc_col1, mc_col2, mc_col3,
           out_valid, state_out, busy
  );

  modport master (
    output in_valid, state_in, in_bypass, mc_result, out_ready,
    input  in_ready, mc_row, mc_col0, mc_col1, mc_col2, mc_col3,
           out_valid, state_out, busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// mixColumns sequencer: walks the 16 bytes of an AES state through an external
// combinational mixColumns byte unit, one byte per cycle, and assembles the result.
// A bypass request (final round) passes the state straight through to the output.
module mix_columns_seq #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int BYTE_W    = 8
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  if (BYTE_W != 8) begin : g_byte_w_check
    $error("mix_columns_seq: BYTE_W must be 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] src_q, src_d;
  logic [127:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;
  logic [1:0]   mc_row_q, mc_row_d;
  logic [7:0]   mc_col0_q, mc_col0_d;
  logic [7:0]   mc_col1_q, mc_col1_d;
  logic [7:0]   mc_col2_q, mc_col2_d;
  logic [7:0]   mc_col3_q, mc_col3_d;
  logic         bypass_s;

  // Byte k of a state lives at bits [127-8k -: 8]; (15-k)*8 is {~k, 3'b000}.
  function automatic logic [7:0] byte_at(input logic [127:0] s, input logic [3:0] k);
    byte_at = s[{~k, 3'b000} +: 8];
  endfunction

  assign bypass_s = BYPASS_EN ? bus.in_bypass : 1'b0;

  // Next-state logic: accept, per-byte capture of the unit result, output handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    src_d       = src_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          src_d = bus.state_in;
          idx_d = 4'd0;
          if (bypass_s) begin
            out_d   = bus.state_in;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        out_d[{~idx_q, 3'b000} +: 8] = bus.mc_result;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        // out_valid rises one cycle after entering DONE; the transfer needs it high.
        if (out_valid_q && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    mc_row_d   = 2'd0;
    mc_col0_d  = 8'd0;
    mc_col1_d  = 8'd0;
    mc_col2_d  = 8'd0;
    mc_col3_d  = 8'd0;
    if (state_d == ST_CALC) begin
      mc_row_d  = idx_d[1:0];
      mc_col0_d = byte_at(src_d, {idx_d[3:2], 2'd0});
      mc_col1_d = byte_at(src_d, {idx_d[3:2], 2'd1});
      mc_col2_d = byte_at(src_d, {idx_d[3:2], 2'd2});
      mc_col3_d = byte_at(src_d, {idx_d[3:2], 2'd3});
    end else begin
      mc_row_d  = 2'd0;
    end
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      src_q       <= 128'd0;
      out_q       <= 128'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      mc_row_q    <= 2'd0;
      mc_col0_q   <= 8'd0;
      mc_col1_q   <= 8'd0;
      mc_col2_q   <= 8'd0;
      mc_col3_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mc_row_q    <= mc_row_d;
      mc_col0_q   <= mc_col0_d;
      mc_col1_q   <= mc_col1_d;
      mc_col2_q   <= mc_col2_d;
      mc_col3_q   <= mc_col3_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = out_q;
  assign bus.mc_row    = mc_row_q;
  assign bus.mc_col0   = mc_col0_q;
  assign bus.mc_col1   = mc_col1_q;
  assign bus.mc_col2   = mc_col2_q;
  assign bus.mc_col3   = mc_col3_q;

endmodule
